// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by the transmitter and the matching receiver.
package i2s_pkg;

    localparam int   SAMPLE_W = 16;
    localparam logic WS_LEFT  = 1'b0;

    // One stereo sample pair as carried across the handshake and on the wire.
    typedef struct packed {
        logic signed [SAMPLE_W-1:0] left;
        logic signed [SAMPLE_W-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock generator: divides clk by 2*CLK_DIV into a registered SCK and
// flags the clk cycle whose edge will move SCK up (rise_tick) or down (fall_tick).
module i2s_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic sck_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          sck_q, sck_d;
    logic          div_wrap;

    assign div_wrap    = en_i && (div_cnt_q == DIV_LAST);
    assign rise_tick_o = div_wrap && !sck_q;
    assign fall_tick_o = div_wrap && sck_q;
    assign sck_o       = sck_q;

    // Next divider count and SCK level; disabling parks both at zero.
    always_comb begin
        div_cnt_d = div_cnt_q;
        sck_d     = sck_q;
        if (!en_i) begin
            div_cnt_d = '0;
            sck_d     = 1'b0;
        end else if (div_wrap) begin
            div_cnt_d = '0;
            sck_d     = !sck_q;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            sck_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
        end
    end

endmodule

// File: rtl/i2s_encoder.sv
// I2S transmitter / bus master. Accepts 16-bit stereo pairs into a one-deep
// holding buffer and serialises them with Philips framing (WS low = left,
// MSB one SCK after the WS edge). All outputs change on the SCK falling
// edge so they are stable around the receiver's rising-edge sample point.
//
// Handshake: a pair transfers on any clk edge where in_valid && in_ready.
// in_ready is simply "holding buffer empty" and never looks at in_valid;
// the producer may hold in_valid high and must keep data stable until the
// transfer edge.
module i2s_encoder
    import i2s_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] left_in,
    input  logic signed [SAMPLE_W-1:0] right_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       sck,
    output logic                       ws,
    output logic                       sd,
    output logic                       frame_start,
    output logic                       underrun
);

    localparam int BW = $clog2(2 * SLOT_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_BITS);

    logic           rise_tick, fall_tick;
    logic           unused_rise_tick;

    logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
    stereo_sample_t hold_q, hold_d;
    logic           hold_valid_q, hold_valid_d;
    stereo_sample_t active_q, active_d;
    logic           ws_q, ws_d;
    logic           sd_q, sd_d;
    logic           frame_start_q, frame_start_d;
    logic           underrun_q, underrun_d;

    logic                accept, wrap, load, in_right;
    logic [BW-1:0]       n, k;
    logic [3:0]          bit_idx;
    logic [SAMPLE_W-1:0] word;

    i2s_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .sck_o       (sck),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick)
    );

    // Only the falling edge drives transmitter state.
    assign unused_rise_tick = rise_tick;

    assign in_ready    = !hold_valid_q;
    assign ws          = ws_q;
    assign sd          = sd_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

    // Handshake, frame counter and serial data for the next SCK falling edge.
    always_comb begin
        accept   = in_valid && !hold_valid_q;
        n        = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        wrap     = fall_tick && (n == '0);
        load     = wrap && hold_valid_q;
        in_right = (n >= SLOT_LEN);
        k        = in_right ? n - SLOT_LEN : n;
        bit_idx  = 4'(BW'(SAMPLE_W - 1) - k);

        bit_cnt_d     = bit_cnt_q;
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;
        active_d      = active_q;
        ws_d          = ws_q;
        sd_d          = sd_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (accept) begin
            hold_d.left  = left_in;
            hold_d.right = right_in;
            hold_valid_d = 1'b1;
        end
        // accept and load are exclusive: load needs a full buffer, accept an empty one.
        if (load) begin
            active_d     = hold_q;
            hold_valid_d = 1'b0;
        end

        // Taken from active_d so the MSB of a freshly loaded frame goes out at once.
        word = in_right ? active_d.right : active_d.left;

        if (!en) begin
            bit_cnt_d = BIT_LAST;
            ws_d      = WS_LEFT;
            sd_d      = 1'b0;
        end else if (fall_tick) begin
            bit_cnt_d     = n;
            // WS switches one bit ahead of the slot it announces.
            ws_d          = (n != BIT_LAST) && (n >= SLOT_LEN - 1'b1);
            sd_d          = (k < BW'(SAMPLE_W)) ? word[bit_idx] : 1'b0;
            frame_start_d = wrap;
            underrun_d    = wrap && !hold_valid_q;
        end
    end

    // Transmitter state registers; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q     <= BIT_LAST;
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            active_q      <= '0;
            ws_q          <= WS_LEFT;
            sd_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            active_q      <= active_d;
            ws_q          <= ws_d;
            sd_q          <= sd_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

endmodule

// File: tb/tb_i2s_encoder.sv
// Directed bench for i2s_encoder: 32-bit-slot instance plus a 17-bit-slot
// instance, each observed by a small I2S receiver model.
module tb_i2s_encoder;

    localparam int CLK_DIV  = 4;
    localparam int SLOT_STD = 32;
    localparam int SLOT_MIN = 17;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en;

    // standard-slot instance
    logic        in_valid, in_ready, sck, ws, sd, frame_start, underrun;
    logic [15:0] left_in, right_in;
    // minimum-slot instance
    logic        in_valid2, in_ready2, sck2, ws2, sd2, fs2, ur2;
    logic [15:0] left2, right2;

    i2s_encoder #(.CLK_DIV(CLK_DIV), .SLOT_BITS(SLOT_STD)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .left_in(left_in), .right_in(right_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .sck(sck), .ws(ws), .sd(sd),
        .frame_start(frame_start), .underrun(underrun)
    );

    i2s_encoder #(.CLK_DIV(CLK_DIV), .SLOT_BITS(SLOT_MIN)) u_dut_min (
        .clk(clk), .rst_n(rst_n), .en(en),
        .left_in(left2), .right_in(right2),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .sck(sck2), .ws(ws2), .sd(sd2),
        .frame_start(fs2), .underrun(ur2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- receiver models (sample on SCK rise) ----------------
    logic [31:0] got_q[$];
    logic [31:0] got2_q[$];
    logic [31:0] exp_q[$];
    logic [15:0] rx_left, rx_right, rx2_left, rx2_right;
    logic        m_armed, m_prev, m_last_ws;
    logic        m2_armed, m2_prev, m2_last_ws;
    int          m_cnt, m2_cnt;
    logic [15:0] m_sr, m2_sr;

    always @(negedge clk) begin
        if (!rst_n || !en) begin
            m_armed = 1'b0; m_prev = 1'b0; m_last_ws = 1'b0; m_cnt = 0;
        end else begin
            if (m_prev && !sck) begin
                m_armed = 1'b1;
            end else if (!m_prev && sck && m_armed) begin
                if (ws !== m_last_ws) begin
                    m_last_ws = ws;
                    m_cnt = 0;
                end else if (m_cnt < 16) begin
                    m_sr = {m_sr[14:0], sd};
                    m_cnt++;
                    if (m_cnt == 16) begin
                        if (ws) begin
                            rx_right = m_sr;
                            got_q.push_back({rx_left, m_sr});
                        end else begin
                            rx_left = m_sr;
                        end
                    end
                end
            end
            m_prev = sck;
        end
    end

    always @(negedge clk) begin
        if (!rst_n || !en) begin
            m2_armed = 1'b0; m2_prev = 1'b0; m2_last_ws = 1'b0; m2_cnt = 0;
        end else begin
            if (m2_prev && !sck2) begin
                m2_armed = 1'b1;
            end else if (!m2_prev && sck2 && m2_armed) begin
                if (ws2 !== m2_last_ws) begin
                    m2_last_ws = ws2;
                    m2_cnt = 0;
                end else if (m2_cnt < 16) begin
                    m2_sr = {m2_sr[14:0], sd2};
                    m2_cnt++;
                    if (m2_cnt == 16) begin
                        if (ws2) begin
                            rx2_right = m2_sr;
                            got2_q.push_back({rx2_left, m2_sr});
                        end else begin
                            rx2_left = m2_sr;
                        end
                    end
                end
            end
            m2_prev = sck2;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    // Waits for frame_start on the standard instance; a missed bound counts as a failure.
    task automatic wait_frame_start(input int budget, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (frame_start === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            $display("FAIL frame_start_timeout: none after %0d clk, required within %0d", cyc, budget);
            cyc = -1;
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; in_valid2 = 1'b0;
        left_in = 16'h1111; right_in = 16'h2222; left2 = '0; right2 = '0;
        step(3);
        n_checks++; if (sck !== 1'b0) $display("FAIL reset_sck: got %b want 0", sck); else n_pass++;
        n_checks++; if (ws !== 1'b0) $display("FAIL reset_ws: got %b want 0", ws); else n_pass++;
        n_checks++; if (sd !== 1'b0) $display("FAIL reset_sd: got %b want 0", sd); else n_pass++;
        n_checks++; if (frame_start !== 1'b0) $display("FAIL reset_frame_start: got %b want 0", frame_start); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else n_pass++;
        // in_valid was high through reset and must have been ignored
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        in_valid = 1'b0;
    endtask

    task automatic test_waveform;
        logic [63:0] sd_stream, ws_stream;
        sd_stream = 64'h8001_0000_7FFE_0000;
        ws_stream = 64'h0000_0001_FFFF_FFFE;
        rst_n = 1'b1; in_valid = 1'b1; left_in = 16'h8001; right_in = 16'h7FFE;
        step(1);
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL wave_hold_full: in_ready got %b want 0", in_ready); else n_pass++;
        step(3);
        n_checks++; if (sck !== 1'b1) $display("FAIL wave_first_rise: sck got %b want 1 at clk 4", sck); else n_pass++;
        step(4);
        n_checks++; if (sck !== 1'b0) $display("FAIL wave_first_fall: sck got %b want 0 at clk 8", sck); else n_pass++;
        n_checks++; if (frame_start !== 1'b1) $display("FAIL wave_frame_start: got %b want 1 at clk 8", frame_start); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL wave_no_underrun: got %b want 0", underrun); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL wave_hold_loaded: in_ready got %b want 1", in_ready); else n_pass++;
        for (int b = 0; b < 64; b++) begin
            if (b > 0) step(8);
            n_checks++;
            if (sd !== sd_stream[63-b]) $display("FAIL wave_sd bit %0d: got %b want %b", b, sd, sd_stream[63-b]);
            else n_pass++;
            n_checks++;
            if (ws !== ws_stream[63-b]) $display("FAIL wave_ws bit %0d: got %b want %b", b, ws, ws_stream[63-b]);
            else n_pass++;
        end
    endtask

    task automatic test_underrun;
        int cyc;
        wait_frame_start(20, cyc);
        n_checks++; if (cyc != 8) $display("FAIL underrun_frame2_time: got %0d clk want 8", cyc); else n_pass++;
        n_checks++; if (underrun !== 1'b1) $display("FAIL underrun_frame2: got %b want 1", underrun); else n_pass++;
        n_checks++; if (rx_left !== 16'h8001) $display("FAIL loop_left: got %h want 8001", rx_left); else n_pass++;
        n_checks++; if (rx_right !== 16'h7FFE) $display("FAIL loop_right: got %h want 7ffe", rx_right); else n_pass++;
        wait_frame_start(600, cyc);
        n_checks++; if (cyc != 512) $display("FAIL frame_period: got %0d clk want 512", cyc); else n_pass++;
        n_checks++; if (underrun !== 1'b1) $display("FAIL underrun_frame3: got %b want 1", underrun); else n_pass++;
        n_checks++; if (rx_left !== 16'h8001 || rx_right !== 16'h7FFE)
            $display("FAIL underrun_repeat: got %h/%h want 8001/7ffe", rx_left, rx_right); else n_pass++;
    endtask

    task automatic test_reset_midframe;
        int cyc;
        step(20 * 8);
        rst_n = 1'b0;
        step(1);
        n_checks++; if ({sck, ws, sd} !== 3'b000) $display("FAIL midreset_outputs: sck/ws/sd got %b want 000", {sck, ws, sd}); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL midreset_in_ready: got %b want 1", in_ready); else n_pass++;
        rst_n = 1'b1; in_valid = 1'b1; left_in = 16'hC357; right_in = 16'h2468;
        step(1);
        in_valid = 1'b0;
        wait_frame_start(20, cyc);
        n_checks++; if (cyc != 7) $display("FAIL midreset_restart_time: got %0d want 7", cyc); else n_pass++;
        n_checks++; if (sd !== 1'b1 || ws !== 1'b0) $display("FAIL midreset_msb: sd/ws got %b%b want 10", sd, ws); else n_pass++;
    endtask

    task automatic test_enable;
        int cyc;
        in_valid = 1'b1; left_in = 16'hA5C3; right_in = 16'h3C5A;
        step(1);
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL en_push: in_ready got %b want 0", in_ready); else n_pass++;
        step(34 * 8 + 4);
        // right slot bit 2 of 16'h2468 is a 1, SCK is high here
        n_checks++; if ({sck, ws, sd} !== 3'b111) $display("FAIL en_pre_drop: sck/ws/sd got %b want 111", {sck, ws, sd}); else n_pass++;
        en = 1'b0;
        step(1);
        n_checks++; if ({sck, ws, sd} !== 3'b000) $display("FAIL en_drop: sck/ws/sd got %b want 000", {sck, ws, sd}); else n_pass++;
        step(30);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL en_hold_kept: in_ready got %b want 0", in_ready); else n_pass++;
        n_checks++; if (sck !== 1'b0) $display("FAIL en_idle_sck: got %b want 0", sck); else n_pass++;
        en = 1'b1;
        wait_frame_start(20, cyc);
        n_checks++; if (cyc != 8) $display("FAIL en_restart_time: got %0d want 8", cyc); else n_pass++;
        n_checks++; if (sd !== 1'b1 || in_ready !== 1'b1) $display("FAIL en_restart_load: sd/in_ready got %b%b want 11", sd, in_ready); else n_pass++;
        wait_frame_start(600, cyc);
        n_checks++; if (rx_left !== 16'hA5C3 || rx_right !== 16'h3C5A)
            $display("FAIL en_held_pair: got %h/%h want a5c3/3c5a", rx_left, rx_right); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] pairs[4];
        logic [31:0] got, exp;
        int idx, frames, ur_cnt, win[4];
        bit rdy;
        pairs[0] = 32'h0001_FFFF; pairs[1] = 32'h7FFF_8000;
        pairs[2] = 32'hDEAD_BEEF; pairs[3] = 32'h5A5A_A5A5;
        idx = 0; frames = 0; ur_cnt = 0;
        for (int i = 0; i < 4; i++) win[i] = 0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        for (int c = 0; c < 2700 && frames < 5; c++) begin
            if (frame_start === 1'b1) begin
                frames++;
                if (frames <= 4 && underrun !== 1'b0) ur_cnt++;
            end
            if (frames >= 1 && frames <= 3 && in_ready === 1'b1) win[frames]++;
            if (frames < 5) begin
                if (idx < 4) begin
                    in_valid = 1'b1;
                    {left_in, right_in} = pairs[idx];
                end else begin
                    in_valid = 1'b0;
                end
                rdy = in_ready;
                @(posedge clk);
                if (rdy && in_valid) begin
                    exp_q.push_back({left_in, right_in});
                    idx++;
                end
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        n_checks++; if (frames != 5) $display("FAIL b2b_frames: got %0d want 5", frames); else n_pass++;
        n_checks++; if (ur_cnt != 0) $display("FAIL b2b_underrun: got %0d pulses want 0", ur_cnt); else n_pass++;
        for (int f = 1; f <= 3; f++) begin
            n_checks++;
            if (win[f] != 1) $display("FAIL b2b_ready_frame%0d: high %0d clk want 1", f, win[f]);
            else n_pass++;
        end
        n_checks++; if (exp_q.size() != 4 || got_q.size() != 4)
            $display("FAIL b2b_count: accepted %0d received %0d want 4/4", exp_q.size(), got_q.size()); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = got_q.pop_front();
            n_checks++;
            if (got !== exp) $display("FAIL b2b_pair: got %h want %h", got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_min_slot;
        int cyc, first_fs, n_fs;
        bit ur_first;
        first_fs = -1; n_fs = 0; ur_first = 1'b0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1; in_valid2 = 1'b1; left2 = 16'h1234; right2 = 16'hFEDC;
        got2_q.delete();
        step(1);
        in_valid2 = 1'b0;
        n_checks++; if (in_ready2 !== 1'b0) $display("FAIL min_push: in_ready got %b want 0", in_ready2); else n_pass++;
        cyc = 0;
        while (cyc < 1200 && n_fs < 2) begin
            @(negedge clk);
            cyc++;
            if (fs2 === 1'b1) begin
                n_fs++;
                if (n_fs == 1) begin
                    first_fs = cyc;
                    ur_first = ur2;
                end
            end
        end
        n_checks++; if (first_fs != 7) $display("FAIL min_first_frame: got %0d want 7", first_fs); else n_pass++;
        n_checks++; if (ur_first !== 1'b0) $display("FAIL min_first_underrun: got %b want 0", ur_first); else n_pass++;
        n_checks++; if (n_fs != 2 || cyc - first_fs != 272)
            $display("FAIL min_frame_period: frames %0d period %0d want 2/272", n_fs, cyc - first_fs); else n_pass++;
        n_checks++; if (ur2 !== 1'b1) $display("FAIL min_second_underrun: got %b want 1", ur2); else n_pass++;
        n_checks++; if (got2_q.size() < 1) $display("FAIL min_loop_count: got %0d pairs want >=1", got2_q.size());
        else if (got2_q[0] !== 32'h1234_FEDC) $display("FAIL min_loop_pair: got %h want 1234fedc", got2_q[0]);
        else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_waveform();
        test_underrun();
        test_reset_midframe();
        test_enable();
        test_back_to_back();
        test_min_slot();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

endmodule
